mem_lock_arbiter: RTL and testbench

Arbitrates the eight cores' shared-memory and lock traffic in front of `main_mem`. It collects each core's read/write requests and lock/unlock requests and serialises memory accesses onto the single memory port. It owns the 16-entry lock table and returns per-core `main_mem_ac` / `lock_ac` acknowledges. It sits between the `core` array and `main_mem` in the multi-core top.

---
 rtl/mem_lock_arbiter_pkg.sv | 29 ++
 rtl/mem_lock_arbiter_rr_pick.sv | 42 ++++
 rtl/mem_lock_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_lock_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lock_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : arb_pkg                                                       |
// | Purpose  : Shared sizes and types for mem_lock_arbiter and rr_pick.      |
// | Contents : C (cores), LOCKS (lock entries), index/data widths,           |
// |            mem_op_t (registered memory op), lock_entry_t (table entry).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package arb_pkg;

  localparam int C      = 8;
  localparam int LOCKS  = 16;
  localparam int IDX_W  = $clog2(C);
  localparam int LOCK_W = $clog2(LOCKS);
  localparam int DW     = 16;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } mem_op_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] owner;
  } lock_entry_t;

endpackage
`default_nettype wire

// File: rtl/mem_lock_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_pick                                                       |
// | Purpose  : Picks one requester, searching upward (with wrap) from i_ptr. |
// |            A pointer held at 0 gives fixed lowest-index priority.        |
// | Ports    : i_req  [C]     request vector                                 |
// |            i_ptr  [IDX_W] index searched first                           |
// |            o_gnt  [C]     one-hot grant (all zero when no request)       |
// |            o_idx  [IDX_W] index of the granted requester                 |
// |            o_any          at least one request present                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rr_pick
  import arb_pkg::*;
(
  input  logic [C-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [C-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < C; k++) begin
      // C is a power of two, so the index wraps naturally at IDX_W bits.
      w_cand = i_ptr + IDX_W'(k);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_lock_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_lock_arbiter                                              |
// | Purpose  : Serialises the cores' read/write traffic onto one main_mem    |
// |            port and owns the LOCKS-entry lock table.                     |
// | Ports    : clk, reset_n (async, active low)                              |
// |            i_main_mem_read/write_request [C], i_main_mem_read_adr,       |
// |            i_main_mem_write_adr, i_main_mem_write_dat [C*16]             |
// |            i_lock_adr [C*4], i_lock_en [C], i_unlock_en [C]              |
// |            o_main_mem_ac [C], o_lock_ac [C], o_mem_adr, o_mem_wdat [16], |
// |            o_mem_we, o_mem_re                                            |
// | Config   : ARB_ROUND_ROBIN_EN defined -> round-robin picks (one pointer  |
// |            for memory, one shared by all lock entries); undefined ->     |
// |            fixed priority, lowest core index wins.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_lock_arbiter
  import arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [C-1:0]        i_main_mem_read_request,
  input  logic [C-1:0]        i_main_mem_write_request,
  input  logic [C*DW-1:0]     i_main_mem_read_adr,
  input  logic [C*DW-1:0]     i_main_mem_write_adr,
  input  logic [C*DW-1:0]     i_main_mem_write_dat,
  input  logic [C*LOCK_W-1:0] i_lock_adr,
  input  logic [C-1:0]        i_lock_en,
  input  logic [C-1:0]        i_unlock_en,
  output logic [C-1:0]        o_main_mem_ac,
  output logic [C-1:0]        o_lock_ac,
  output logic [DW-1:0]       o_mem_adr,
  output logic [DW-1:0]       o_mem_wdat,
  output logic                o_mem_we,
  output logic                o_mem_re
);

  // ---------------- memory path ----------------
  logic [C-1:0]     r_main_mem_ac;
  mem_op_t          r_mem_op;
  logic [DW-1:0]    r_mem_adr;
  logic [DW-1:0]    r_mem_wdat;

  logic [C-1:0]     w_mem_req;
  logic [C-1:0]     w_mem_gnt;
  logic [IDX_W-1:0] w_mem_idx;
  logic [IDX_W-1:0] w_mem_ptr;
  logic             w_mem_any;
  mem_op_t          w_op_nxt;
  logic [DW-1:0]    w_adr_nxt;
  logic [DW-1:0]    w_wdat_nxt;

  // The core being acknowledged this cycle still shows its request (it drops
  // it only after sampling the ack), so it is masked to avoid a double grant.
  assign w_mem_req = (i_main_mem_read_request | i_main_mem_write_request) & ~r_main_mem_ac;

  rr_pick u_mem_pick (
    .i_req (w_mem_req),
    .i_ptr (w_mem_ptr),
    .o_gnt (w_mem_gnt),
    .o_idx (w_mem_idx),
    .o_any (w_mem_any)
  );

  // Write wins over a simultaneous read from the same core; the read stays
  // pending and competes again later.
  always_comb begin
    w_op_nxt   = OP_NONE;
    w_adr_nxt  = '0;
    w_wdat_nxt = '0;
    if (w_mem_any) begin
      if (i_main_mem_write_request[w_mem_idx]) begin
        w_op_nxt   = OP_WRITE;
        w_adr_nxt  = i_main_mem_write_adr[w_mem_idx*DW +: DW];
        w_wdat_nxt = i_main_mem_write_dat[w_mem_idx*DW +: DW];
      end else begin
        w_op_nxt   = OP_READ;
        w_adr_nxt  = i_main_mem_read_adr[w_mem_idx*DW +: DW];
      end
    end
  end

  // ---------------- lock path ----------------
  lock_entry_t [LOCKS-1:0]            r_lock_tbl;
  logic [C-1:0]                       r_lock_ac;
  lock_entry_t [LOCKS-1:0]            w_tbl_nxt;
  logic [C-1:0]                       w_lock_ac_nxt;
  logic [LOCKS-1:0][C-1:0]            w_lock_req;
  logic [LOCKS-1:0][C-1:0]            w_lock_gnt;
  logic [LOCKS-1:0][IDX_W-1:0]        w_lock_idx;
  logic [LOCKS-1:0]                   w_lock_any;
  logic [IDX_W-1:0]                   w_lock_ptr;

  // Only free entries take acquire requests; the held/free test uses the
  // pre-edge table, so an unlock and an acquire in the same cycle resolve
  // as "release now, grant next cycle".
  for (genvar e = 0; e < LOCKS; e++) begin : g_lock
    for (genvar i = 0; i < C; i++) begin : g_core
      assign w_lock_req[e][i] = i_lock_en[i] && !r_lock_tbl[e].valid &&
                                (i_lock_adr[i*LOCK_W +: LOCK_W] == LOCK_W'(e));
    end

    rr_pick u_lock_pick (
      .i_req (w_lock_req[e]),
      .i_ptr (w_lock_ptr),
      .o_gnt (w_lock_gnt[e]),
      .o_idx (w_lock_idx[e]),
      .o_any (w_lock_any[e])
    );
  end

  // An entry is either free (can be granted) or held (can be released), so
  // grant and release never touch the same entry on one edge.
  always_comb begin
    w_tbl_nxt     = r_lock_tbl;
    w_lock_ac_nxt = '0;
    for (int e = 0; e < LOCKS; e++) begin
      if (w_lock_any[e]) begin
        w_tbl_nxt[e].valid = 1'b1;
        w_tbl_nxt[e].owner = w_lock_idx[e];
        w_lock_ac_nxt      = w_lock_ac_nxt | w_lock_gnt[e];
      end else if (r_lock_tbl[e].valid) begin
        for (int i = 0; i < C; i++) begin
          if (i_unlock_en[i] && (i_lock_adr[i*LOCK_W +: LOCK_W] == LOCK_W'(e)) &&
              (r_lock_tbl[e].owner == IDX_W'(i))) begin
            w_tbl_nxt[e].valid = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- priority pointers ----------------
`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_mem_ptr;
  logic [IDX_W-1:0] r_lock_ptr;
  logic [IDX_W-1:0] w_lock_ptr_nxt;

  // Shared lock pointer follows the winner of the lowest-numbered entry
  // granted on this edge.
  always_comb begin
    w_lock_ptr_nxt = r_lock_ptr;
    for (int e = LOCKS - 1; e >= 0; e--) begin
      if (w_lock_any[e]) begin
        w_lock_ptr_nxt = w_lock_idx[e] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_ptr  <= '0;
      r_lock_ptr <= '0;
    end else begin
      if (w_mem_any) begin
        r_mem_ptr <= w_mem_idx + 1'b1;
      end
      r_lock_ptr <= w_lock_ptr_nxt;
    end
  end

  assign w_mem_ptr  = r_mem_ptr;
  assign w_lock_ptr = r_lock_ptr;
`else
  assign w_mem_ptr  = '0;
  assign w_lock_ptr = '0;
`endif

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_main_mem_ac <= '0;
      r_mem_op      <= OP_NONE;
      r_mem_adr     <= '0;
      r_mem_wdat    <= '0;
      r_lock_tbl    <= '0;
      r_lock_ac     <= '0;
    end else begin
      r_main_mem_ac <= w_mem_gnt;
      r_mem_op      <= w_op_nxt;
      r_mem_adr     <= w_adr_nxt;
      r_mem_wdat    <= w_wdat_nxt;
      r_lock_tbl    <= w_tbl_nxt;
      r_lock_ac     <= w_lock_ac_nxt;
    end
  end

  assign o_main_mem_ac = r_main_mem_ac;
  assign o_lock_ac     = r_lock_ac;
  assign o_mem_adr     = r_mem_adr;
  assign o_mem_wdat    = r_mem_wdat;
  assign o_mem_we      = (r_mem_op == OP_WRITE);
  assign o_mem_re      = (r_mem_op == OP_READ);

endmodule
`default_nettype wire

// File: tb/tb_mem_lock_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_lock_arbiter                                           |
// | Purpose  : Self-checking bench for mem_lock_arbiter: directed scenarios  |
// |            followed by random core traffic, all compared each cycle      |
// |            against a behavioural model of the arbitration rules.         |
// | Config   : follows ARB_ROUND_ROBIN_EN in the same way as the design.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_lock_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  // Core-side stimulus, one element per core.
  logic [7:0]  rd, wr, lken, unl;
  logic [15:0] radr [8];
  logic [15:0] wadr [8];
  logic [15:0] wdat [8];
  logic [3:0]  ladr [8];
  int          cstate [8];   // 0 idle, 1 waiting for a lock, 2 owns ladr

  logic [127:0] p_radr, p_wadr, p_wdat;
  logic [31:0]  p_ladr;
  always_comb begin
    p_radr = '0;
    p_wadr = '0;
    p_wdat = '0;
    p_ladr = '0;
    for (int c = 0; c < 8; c++) begin
      p_radr[c*16 +: 16] = radr[c];
      p_wadr[c*16 +: 16] = wadr[c];
      p_wdat[c*16 +: 16] = wdat[c];
      p_ladr[c*4 +: 4]   = ladr[c];
    end
  end

  logic [7:0]  o_ac, o_lac;
  logic [15:0] o_adr, o_wdat;
  logic        o_we, o_re;

  mem_lock_arbiter dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .i_main_mem_read_request  (rd),
    .i_main_mem_write_request (wr),
    .i_main_mem_read_adr      (p_radr),
    .i_main_mem_write_adr     (p_wadr),
    .i_main_mem_write_dat     (p_wdat),
    .i_lock_adr               (p_ladr),
    .i_lock_en                (lken),
    .i_unlock_en              (unl),
    .o_main_mem_ac            (o_ac),
    .o_lock_ac                (o_lac),
    .o_mem_adr                (o_adr),
    .o_mem_wdat               (o_wdat),
    .o_mem_we                 (o_we),
    .o_mem_re                 (o_re)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- behavioural model ----------------
  int          m_last;            // core acknowledged in the upcoming cycle
  int          m_ptr, m_lptr;
  bit          m_valid [16];
  int          m_owner [16];
  logic [7:0]  e_ac, e_lac;
  logic [15:0] e_adr, e_wdat;
  logic        e_we, e_re;

  function automatic void model_reset();
    m_last = -1; m_ptr = 0; m_lptr = 0;
    e_ac = '0; e_lac = '0; e_adr = '0; e_wdat = '0; e_we = 1'b0; e_re = 1'b0;
    for (int e = 0; e < 16; e++) begin m_valid[e] = 1'b0; m_owner[e] = 0; end
  endfunction

  // Outputs expected after the next rising edge given the current inputs.
  function automatic void model_step();
    int w, c, lw_first;
    w = -1;
    for (int k = 0; k < 8; k++) begin
      c = (m_ptr + k) % 8;
      if (w < 0 && (rd[c] || wr[c]) && c != m_last) w = c;
    end
    e_ac = '0; e_we = 1'b0; e_re = 1'b0; e_adr = '0; e_wdat = '0;
    m_last = w;
    if (w >= 0) begin
      e_ac[w] = 1'b1;
      if (wr[w]) begin e_we = 1'b1; e_adr = wadr[w]; e_wdat = wdat[w]; end
      else       begin e_re = 1'b1; e_adr = radr[w]; end
`ifdef ARB_ROUND_ROBIN_EN
      m_ptr = (w + 1) % 8;
`endif
    end
    e_lac = '0;
    lw_first = -1;
    for (int e = 0; e < 16; e++) begin
      if (!m_valid[e]) begin
        w = -1;
        for (int k = 0; k < 8; k++) begin
          c = (m_lptr + k) % 8;
          if (w < 0 && lken[c] && ladr[c] == 4'(e)) w = c;
        end
        if (w >= 0) begin
          m_valid[e] = 1'b1; m_owner[e] = w; e_lac[w] = 1'b1;
          if (lw_first < 0) lw_first = w;
        end
      end else begin
        for (int c2 = 0; c2 < 8; c2++)
          if (unl[c2] && ladr[c2] == 4'(e) && m_owner[e] == c2) m_valid[e] = 1'b0;
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    if (lw_first >= 0) m_lptr = (lw_first + 1) % 8;
`endif
  endfunction

  function automatic void clear_inputs();
    rd = '0; wr = '0; lken = '0; unl = '0;
    for (int c = 0; c < 8; c++) begin
      radr[c] = '0; wadr[c] = '0; wdat[c] = '0; ladr[c] = '0; cstate[c] = 0;
    end
  endfunction

  // One clock: predict, let the edge happen, compare, then the cores react
  // to their acks the way real cores would (drop the served request).
  task automatic cycle();
    model_step();
    @(posedge clk); #1;
    chk("main_mem_ac", 32'(o_ac),   32'(e_ac));
    chk("mem_we",      32'(o_we),   32'(e_we));
    chk("mem_re",      32'(o_re),   32'(e_re));
    chk("mem_adr",     32'(o_adr),  32'(e_adr));
    chk("mem_wdat",    32'(o_wdat), 32'(e_wdat));
    chk("lock_ac",     32'(o_lac),  32'(e_lac));
    for (int c = 0; c < 8; c++) begin
      if (e_ac[c]) begin
        if (e_we) wr[c] = 1'b0; else rd[c] = 1'b0;
      end
      unl[c] = 1'b0;
      if (e_lac[c]) begin lken[c] = 1'b0; cstate[c] = 2; end
    end
  endtask

  task automatic rand_inputs();
    for (int c = 0; c < 8; c++) begin
      if (!rd[c] && !wr[c] && $urandom_range(2) == 0) begin
        case ($urandom_range(2))
          0:       rd[c] = 1'b1;
          1:       wr[c] = 1'b1;
          default: begin rd[c] = 1'b1; wr[c] = 1'b1; end
        endcase
        radr[c] = 16'($urandom); wadr[c] = 16'($urandom); wdat[c] = 16'($urandom);
      end
      if (cstate[c] == 0) begin
        case ($urandom_range(5))
          0: begin lken[c] = 1'b1; ladr[c] = 4'($urandom_range(3)); cstate[c] = 1; end
          1: begin unl[c] = 1'b1;  ladr[c] = 4'($urandom_range(3)); end  // stray release
          default: ;
        endcase
      end else if (cstate[c] == 2 && $urandom_range(3) == 0) begin
        unl[c] = 1'b1; cstate[c] = 0;
      end
    end
  endtask

  logic [7:0] exp_pat;

  initial begin
    clear_inputs();
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ac", 32'(o_ac), 0);   chk("rst_lac", 32'(o_lac), 0);
    chk("rst_we", 32'(o_we), 0);   chk("rst_re", 32'(o_re), 0);
    chk("rst_adr", 32'(o_adr), 0); chk("rst_wdat", 32'(o_wdat), 0);
    @(negedge clk) reset_n = 1'b1;

    // Single write from core 3
    wr[3] = 1'b1; wadr[3] = 16'h0040; wdat[3] = 16'hBEEF;
    cycle();
    chk("w3_ac", 32'(o_ac), 32'h08);   chk("w3_we", 32'(o_we), 1);
    chk("w3_adr", 32'(o_adr), 32'h0040); chk("w3_wdat", 32'(o_wdat), 32'hBEEF);
    cycle();
    chk("w3_idle_ac", 32'(o_ac), 0);   chk("w3_idle_we", 32'(o_we), 0);

    // All cores reading continuously
    for (int i = 0; i < 16; i++) begin
      rd = 8'hFF;
      cycle();
`ifdef ARB_ROUND_ROBIN_EN
      exp_pat = 8'(1 << ((4 + i) % 8));
`else
      exp_pat = 8'(1 << (i % 2));
`endif
      chk("allrd_ac", 32'(o_ac), 32'(exp_pat));
    end
    rd = '0;
    cycle();

    // Core 2 read and write together: write first, read two cycles later
    rd[2] = 1'b1; wr[2] = 1'b1; radr[2] = 16'h1111; wadr[2] = 16'h2222; wdat[2] = 16'h3333;
    cycle();
    chk("rw_first_ac", 32'(o_ac), 32'h04); chk("rw_first_we", 32'(o_we), 1);
    cycle();
    chk("rw_gap_ac", 32'(o_ac), 0);
    cycle();
    chk("rw_read_ac", 32'(o_ac), 32'h04); chk("rw_read_re", 32'(o_re), 1);
    chk("rw_read_adr", 32'(o_adr), 32'h1111);
    cycle();

    // Lock contention on entry 7
    lken[1] = 1'b1; ladr[1] = 4'd7; lken[5] = 1'b1; ladr[5] = 4'd7;
    cycle();
    chk("lk_c1_ack", 32'(o_lac), 32'h02);
    cycle();
    chk("lk_c5_wait", 32'(o_lac), 0);
    unl[5] = 1'b1;                       // non-owner release
    cycle();
    chk("lk_nonowner", 32'(o_lac), 0);
    cycle();
    chk("lk_still_held", 32'(o_lac), 0);
    unl[1] = 1'b1; cstate[1] = 0;        // owner release
    cycle();
    chk("lk_unlock_edge", 32'(o_lac), 0);
    cycle();
    chk("lk_c5_ack", 32'(o_lac), 32'h20);

    // Asynchronous reset during a granted write
    wr[0] = 1'b1; wadr[0] = 16'h1234; wdat[0] = 16'h5678;
    cycle();
    chk("ar_pre_ac", 32'(o_ac), 32'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_ac", 32'(o_ac), 0); chk("ar_we", 32'(o_we), 0); chk("ar_lac", 32'(o_lac), 0);
    clear_inputs();
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    lken[2] = 1'b1; ladr[2] = 4'd7;      // entry 7 must be free again
    cycle();
    chk("ar_lock_free", 32'(o_lac), 32'h04);
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
